branch_ctrl: RTL and testbench

- Sequences conditional branch resolution against the processor's Z/V/N flag state.
- Tracks outstanding flag-setting instructions with a pending counter.
- Holds a branch in decode until the flags are final, then evaluates the 3-bit condition and issues a one-cycle PC redirect/flush when the branch is taken.
- Sits between the decode stage, the ALU flag outputs and the PC/fetch logic; also keeps branch statistics counters.

---
 rtl/branch_ctrl_pkg.sv | 24 ++
 rtl/branch_ctrl_cond_eval.sv | 32 +++
 rtl/branch_ctrl.sv | 173 +++++++++++++++++
 tb/tb_branch_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the conditional branch controller: condition codes,
// FSM state encoding and the bit positions of the Z/V/N flags.
package branch_ctrl_pkg;

  localparam logic [2:0] COND_EQ     = 3'b000;
  localparam logic [2:0] COND_LT     = 3'b001;
  localparam logic [2:0] COND_GT     = 3'b010;
  localparam logic [2:0] COND_OV     = 3'b011;
  localparam logic [2:0] COND_NE     = 3'b100;
  localparam logic [2:0] COND_GE     = 3'b101;
  localparam logic [2:0] COND_LE     = 3'b110;
  localparam logic [2:0] COND_ALWAYS = 3'b111;

  localparam int FLAG_N = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESOLVE = 2'd2
  } state_t;

endpackage

// File: rtl/branch_ctrl_cond_eval.sv
// Pure combinational condition evaluator; shared with the jump/predicate logic.
module cond_eval
  import branch_ctrl_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] zvn,
  output logic       taken
);

  logic fz, fv, fn;

  assign fz = zvn[FLAG_Z];
  assign fv = zvn[FLAG_V];
  assign fn = zvn[FLAG_N];

  // Decode the 3-bit condition against the supplied flag vector.
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ:     taken = fz;
      COND_LT:     taken = fn & ~fv;
      COND_GT:     taken = ~fz & ~fv & ~fn;
      COND_OV:     taken = fv;
      COND_NE:     taken = ~fz;
      COND_GE:     taken = fv | ~fn;
      COND_LE:     taken = (fn & ~fv) | fz;
      COND_ALWAYS: taken = 1'b1;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// Conditional branch controller: holds a decoded branch until all outstanding
// flag writers have retired, evaluates its condition on the registered flags
// and emits a one-cycle redirect/flush when taken. Keeps branch statistics.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int PEND_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fs_issue,
  input  logic              flag_wr,
  input  logic              z,
  input  logic              v,
  input  logic              n,
  input  logic              br_valid,
  input  logic [2:0]        br_cond,
  input  logic [ADDR_W-1:0] br_target,
  output logic              br_ready,
  output logic              stall,
  output logic              pend_full,
  output logic              redirect,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  tkn_cnt,
  output logic              err
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            state_reg, state_next;
  logic [2:0]        zvn_reg;
  logic [2:0]        flag_in;
  logic [PEND_W-1:0] pend_reg;
  logic              err_reg;
  logic [ADDR_W-1:0] target_reg;
  logic              taken_reg;
  logic              taken_now;
  logic              clear;
  logic              accept;
  logic [CNT_W-1:0]  br_cnt_reg, tkn_cnt_reg;

  assign flag_in[FLAG_Z] = z;
  assign flag_in[FLAG_V] = v;
  assign flag_in[FLAG_N] = n;

  // Conditions always look at the registered flags, never the live ALU bus.
  cond_eval u_cond_eval (
    .cond  (br_cond),
    .zvn   (zvn_reg),
    .taken (taken_now)
  );

  // Flags are final only when nothing is outstanding and nothing lands now.
  assign clear     = (pend_reg == '0) && !flag_wr;
  assign pend_full = (pend_reg == PEND_MAX);
  assign err       = err_reg;
  assign br_cnt    = br_cnt_reg;
  assign tkn_cnt   = tkn_cnt_reg;

  // Capture the ALU flags whenever they are written.
  always_ff @(posedge clk) begin
    if (rst) begin
      zvn_reg <= '0;
    end else if (flag_wr) begin
      zvn_reg <= flag_in;
    end
  end

  // Outstanding flag-writer count; saturating moves are refused and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg <= '0;
      err_reg  <= 1'b0;
    end else if (fs_issue && !flag_wr) begin
      if (pend_reg == PEND_MAX) begin
        err_reg <= 1'b1;
      end else begin
        pend_reg <= pend_reg + PEND_W'(1);
      end
    end else if (flag_wr && !fs_issue) begin
      if (pend_reg == '0) begin
        err_reg <= 1'b1;
      end else begin
        pend_reg <= pend_reg - PEND_W'(1);
      end
    end
  end

  // Next-state and handshake/redirect outputs; reset suppresses every pulse.
  always_comb begin
    state_next = state_reg;
    br_ready   = 1'b0;
    stall      = 1'b0;
    redirect   = 1'b0;
    flush      = 1'b0;
    accept     = 1'b0;
    if (rst) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (br_valid) begin
            if (clear) begin
              br_ready   = 1'b1;
              accept     = 1'b1;
              state_next = ST_RESOLVE;
            end else begin
              stall      = 1'b1;
              state_next = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          stall = 1'b1;
          if (!br_valid) begin
            state_next = ST_IDLE;
          end else if (clear) begin
            br_ready   = 1'b1;
            accept     = 1'b1;
            state_next = ST_RESOLVE;
          end
        end
        ST_RESOLVE: begin
          stall      = 1'b1;
          redirect   = taken_reg;
          flush      = taken_reg;
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign redirect_pc = redirect ? target_reg : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Latch the accepted branch's target and its already-decided outcome.
  always_ff @(posedge clk) begin
    if (rst) begin
      target_reg <= '0;
      taken_reg  <= 1'b0;
    end else if (accept) begin
      target_reg <= br_target;
      taken_reg  <= taken_now;
    end
  end

  // Statistics: every resolved branch, and the taken subset; both wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_reg  <= '0;
      tkn_cnt_reg <= '0;
    end else if (state_reg == ST_RESOLVE) begin
      br_cnt_reg <= br_cnt_reg + CNT_W'(1);
      if (taken_reg) begin
        tkn_cnt_reg <= tkn_cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: table of condition vectors plus
// hand-written multi-cycle sequences, with a redirect scoreboard queue.
module tb_branch_ctrl;

  localparam int ADDR_W = 16;
  localparam int PEND_W = 2;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              fs_issue, flag_wr, z, v, n;
  logic              br_valid;
  logic [2:0]        br_cond;
  logic [ADDR_W-1:0] br_target;
  logic              br_ready, stall, pend_full, redirect, flush, err;
  logic [ADDR_W-1:0] redirect_pc;
  logic [CNT_W-1:0]  br_cnt, tkn_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        z, v, n;
    logic [2:0]  cond;
    logic [15:0] target;
    logic        taken;
  } vec_t;

  typedef struct {
    logic        taken;
    logic [15:0] pc;
  } sb_t;

  vec_t vecs[16];
  sb_t  sb[$];
  logic [CNT_W-1:0] exp_br, exp_tkn;

  branch_ctrl #(.ADDR_W(ADDR_W), .PEND_W(PEND_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .fs_issue(fs_issue), .flag_wr(flag_wr),
    .z(z), .v(v), .n(n), .br_valid(br_valid), .br_cond(br_cond),
    .br_target(br_target), .br_ready(br_ready), .stall(stall),
    .pend_full(pend_full), .redirect(redirect), .flush(flush),
    .redirect_pc(redirect_pc), .br_cnt(br_cnt), .tkn_cnt(tkn_cnt), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  // One flag writer: issue, then its flag write, then an idle cycle.
  task automatic set_flags(input logic fz, input logic fv, input logic fn);
    step(); fs_issue = 1'b1;
    samp();
    step(); fs_issue = 1'b0; flag_wr = 1'b1; z = fz; v = fv; n = fn;
    samp();
    step(); flag_wr = 1'b0;
    samp();
  endtask

  // After an accepting negedge: check the RESOLVE cycle against the scoreboard.
  task automatic resolve_and_check(input string tag);
    sb_t e;
    step(); br_valid = 1'b0;
    samp();
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_redirect"}, {31'd0, redirect}, {31'd0, e.taken});
      check({tag, "_flush"}, {31'd0, flush}, {31'd0, e.taken});
      check({tag, "_pc"}, {16'd0, redirect_pc}, e.taken ? {16'd0, e.pc} : 32'd0);
      check({tag, "_stall_resolve"}, {31'd0, stall}, 32'd1);
      check({tag, "_no_ready"}, {31'd0, br_ready}, 32'd0);
      exp_br = exp_br + 1'b1;
      if (e.taken) exp_tkn = exp_tkn + 1'b1;
    end
    step();
    samp();
    check({tag, "_br_cnt"}, {24'd0, br_cnt}, {24'd0, exp_br});
    check({tag, "_tkn_cnt"}, {24'd0, tkn_cnt}, {24'd0, exp_tkn});
    check({tag, "_redirect_done"}, {31'd0, redirect}, 32'd0);
  endtask

  // Present a branch, wait (bounded) for acceptance, then check the outcome.
  task automatic do_branch(input logic [2:0] c, input logic [15:0] t, input logic exp_t,
                           input int exp_lat, input string tag);
    bit got = 0;
    int lat = 0;
    step(); br_valid = 1'b1; br_cond = c; br_target = t;
    for (int i = 0; i < 20 && !got; i++) begin
      samp();
      if (br_ready === 1'b1) begin
        got = 1;
      end else begin
        lat++;
        step();
      end
    end
    check({tag, "_accepted"}, {31'd0, got}, 32'd1);
    if (got) begin
      if (exp_lat >= 0) check({tag, "_latency"}, lat, exp_lat);
      sb.push_back('{taken: exp_t, pc: t});
      resolve_and_check(tag);
    end else begin
      br_valid = 1'b0;
    end
  endtask

  initial begin
    // zvn vectors: {z,v,n}
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'b000, 16'h0040, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 3'b100, 16'h0044, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 3'b110, 16'h0048, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 3'b010, 16'h004c, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 3'b001, 16'h1000, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 3'b101, 16'h1004, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 3'b110, 16'h1008, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 3'b000, 16'h100c, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 3'b010, 16'h2000, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 3'b100, 16'h2004, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 3'b011, 16'h2008, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 3'b001, 16'h3000, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 3'b101, 16'h3004, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 3'b110, 16'h3008, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 3'b011, 16'h300c, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 3'b111, 16'hfffe, 1'b1};

    rst = 1'b1; fs_issue = 1'b0; flag_wr = 1'b0; z = 1'b0; v = 1'b0; n = 1'b0;
    br_valid = 1'b0; br_cond = 3'b000; br_target = '0;
    exp_br = '0; exp_tkn = '0;
    repeat (3) step();
    rst = 1'b0;
    samp();
    check("reset_stall", {31'd0, stall}, 0);
    check("reset_redirect", {31'd0, redirect}, 0);
    check("reset_ready", {31'd0, br_ready}, 0);
    check("reset_pend_full", {31'd0, pend_full}, 0);
    check("reset_err", {31'd0, err}, 0);
    check("reset_br_cnt", {24'd0, br_cnt}, 0);
    check("reset_tkn_cnt", {24'd0, tkn_cnt}, 0);

    // Condition table (first entry is the basic EQ-taken scenario).
    for (int i = 0; i < 16; i++) begin
      set_flags(vecs[i].z, vecs[i].v, vecs[i].n);
      do_branch(vecs[i].cond, vecs[i].target, vecs[i].taken, 0, $sformatf("vec%0d", i));
    end
    check("vec_err_clear", {31'd0, err}, 0);

    // Branch waits for two outstanding flag writers.
    step(); fs_issue = 1'b1;
    samp();
    step();
    samp();
    step(); fs_issue = 1'b0; br_valid = 1'b1; br_cond = 3'b100; br_target = 16'h0100;
    samp();
    check("wait_pend2_stall", {31'd0, stall}, 1);
    check("wait_pend2_ready", {31'd0, br_ready}, 0);
    step(); flag_wr = 1'b1; z = 1'b1; v = 1'b0; n = 1'b0;
    samp();
    check("wait_pend1_stall", {31'd0, stall}, 1);
    check("wait_pend1_ready", {31'd0, br_ready}, 0);
    step(); z = 1'b0;
    samp();
    check("wait_lastwr_stall", {31'd0, stall}, 1);
    check("wait_lastwr_ready", {31'd0, br_ready}, 0);
    step(); flag_wr = 1'b0;
    samp();
    check("wait_accept", {31'd0, br_ready}, 1);
    check("wait_accept_stall", {31'd0, stall}, 1);
    if (br_ready === 1'b1) begin
      sb.push_back('{taken: 1'b1, pc: 16'h0100});
      resolve_and_check("wait");
    end else begin
      br_valid = 1'b0;
    end

    // Simultaneous issue and write at pend=1 keeps pend at 1.
    step(); fs_issue = 1'b1;
    samp();
    step(); flag_wr = 1'b1; z = 1'b0; v = 1'b0; n = 1'b0;
    samp();
    step(); fs_issue = 1'b0; flag_wr = 1'b0;
    br_valid = 1'b1; br_cond = 3'b111; br_target = 16'h0200;
    samp();
    check("both_pend1_stall", {31'd0, stall}, 1);
    check("both_pend1_ready", {31'd0, br_ready}, 0);
    step(); flag_wr = 1'b1;
    samp();
    check("both_drain_ready", {31'd0, br_ready}, 0);
    step(); flag_wr = 1'b0;
    samp();
    check("both_accept", {31'd0, br_ready}, 1);
    if (br_ready === 1'b1) begin
      sb.push_back('{taken: 1'b1, pc: 16'h0200});
      resolve_and_check("both");
    end else begin
      br_valid = 1'b0;
    end
    check("both_err_clear", {31'd0, err}, 0);

    // Fill the pending counter and overflow it.
    step(); fs_issue = 1'b1;
    samp();
    check("fill_p0_full", {31'd0, pend_full}, 0);
    step();
    samp();
    step();
    samp();
    check("fill_p2_full", {31'd0, pend_full}, 0);
    step();
    samp();
    check("fill_p3_full", {31'd0, pend_full}, 1);
    check("fill_p3_err", {31'd0, err}, 0);
    step(); fs_issue = 1'b0;
    samp();
    check("ovf_full", {31'd0, pend_full}, 1);
    check("ovf_err", {31'd0, err}, 1);

    // Reset during WAIT with pend=2 abandons the branch.
    step(); flag_wr = 1'b1;
    samp();
    step(); flag_wr = 1'b0; br_valid = 1'b1; br_cond = 3'b111; br_target = 16'h0bad;
    samp();
    check("rstw_stall", {31'd0, stall}, 1);
    check("rstw_full", {31'd0, pend_full}, 0);
    step();
    samp();
    check("rstw_wait_ready", {31'd0, br_ready}, 0);
    step(); rst = 1'b1;
    samp();
    check("rstw_rst_redirect", {31'd0, redirect}, 0);
    check("rstw_rst_ready", {31'd0, br_ready}, 0);
    step(); rst = 1'b0; br_valid = 1'b0;
    samp();
    check("rstw_stall_after", {31'd0, stall}, 0);
    check("rstw_err_after", {31'd0, err}, 0);
    check("rstw_br_cnt_after", {24'd0, br_cnt}, 0);
    exp_br = '0; exp_tkn = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      samp();
      check($sformatf("rstw_no_redirect%0d", i), {31'd0, redirect}, 0);
    end

    // ALWAYS with pend=0, zvn=000, enough times to wrap the counters.
    for (int i = 0; i < (1 << CNT_W); i++) begin
      do_branch(3'b111, 16'(i * 4), 1'b1, 0, $sformatf("wrap%0d", i));
    end
    check("wrap_br_cnt_zero", {24'd0, br_cnt}, 0);
    check("wrap_tkn_cnt_zero", {24'd0, tkn_cnt}, 0);

    // After reset zvn=000 so EQ is not taken, accepted with no stall.
    do_branch(3'b000, 16'h0055, 1'b0, 0, "post_eq");
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
